// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_LAT_MAX = 15;
    localparam int DMEM_CNT_W   = $clog2(DMEM_LAT_MAX + 1);

    function automatic int dmem_lanes(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port DEPTH x DATA_W storage, byte-lane write, registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int LANES  = dmem_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [LANES-1:0]  be_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents survive reset; they start at zero only at power-up.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q = '0;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with request/response handshakes
// Optional byte-lane stores enabled by defining DMEM_BYTE_WRITE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err
);

    localparam int LANES = dmem_lanes(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]           DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [DMEM_CNT_W-1:0]     LAT_M1  = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    wr_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    load_ok_q;
    logic                    err_q;

    logic                    accept;
    logic                    commit;
    logic                    c_write;
    logic [ADDR_W-1:0]       c_addr;
    logic [DATA_W-1:0]       c_wdata;
    logic [LANES-1:0]        c_be;
    logic                    in_range;
    logic [DATA_W-1:0]       arr_rdata;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // With LATENCY==1 the commit happens on the accept edge, so it must see the live request.
    assign c_write = (state_q == IDLE) ? req_write : wr_q;
    assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_BYTE_WRITE_EN
    logic [LANES-1:0] be_q;
    assign c_be = (state_q == IDLE) ? req_be : be_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            be_q <= req_be;
        end
    end
`else
    assign c_be = '1;
`endif

    assign in_range = ({1'b0, c_addr} < DEPTH_X);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - DMEM_CNT_W'(1);
                if (cnt_q == DMEM_CNT_W'(1)) begin
                    state_d = RESP;
                    commit  = !rst;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            load_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                load_ok_q <= in_range && !c_write;
                err_q     <= !in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .LANES  (LANES)
    ) u_array (
        .clk     (clk),
        .we_i    (commit && in_range && c_write),
        .re_i    (commit && in_range && !c_write),
        .addr_i  (c_addr[IDX_W-1:0]),
        .wdata_i (c_wdata),
        .be_i    (c_be),
        .rdata_o (arr_rdata)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = load_ok_q ? arr_rdata : '0;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and LATENCY 1
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;
    logic        va, vb;

    logic        rr_a, rv_a, re_a;
    logic [31:0] rd_a;
    logic        rr_b, rv_b, re_b;
    logic [31:0] rd_b;

    logic        sel;
    logic        m_rr, m_rv, m_re;
    logic [31:0] m_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign m_rr = sel ? rr_b : rr_a;
    assign m_rv = sel ? rv_b : rv_a;
    assign m_re = sel ? re_b : re_a;
    assign m_rd = sel ? rd_b : rd_a;

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (va),
        .req_ready  (rr_a),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be     (req_be),
`endif
        .resp_valid (rv_a),
        .resp_ready (resp_ready),
        .resp_rdata (rd_a),
        .resp_err   (re_a)
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (vb),
        .req_ready  (rr_b),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be     (req_be),
`endif
        .resp_valid (rv_b),
        .resp_ready (resp_ready),
        .resp_rdata (rd_b),
        .resp_err   (re_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) vb = v;
        else     va = v;
    endtask

    // One transaction: accept, count edges to resp_valid, optionally stall, then handshake.
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        bit got;
        @(negedge clk);
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = (hold == 0);
        set_valid(1'b1);
        chk({tag, ".req_ready"}, 32'(m_rr), 32'd1);
        @(posedge clk);
        #1;
        set_valid(1'b0);
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_be    = ~be;
        lat = 1;
        got = m_rv;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            got = m_rv;
        end
        chk({tag, ".resp_valid_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, m_rd, exp_rdata);
        chk({tag, ".err"}, 32'(m_re), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            set_valid(i[0]);
            req_addr = 32'(i * 3);
            chk({tag, ".hold_valid"}, 32'(m_rv), 32'd1);
            chk({tag, ".hold_rdata"}, m_rd, exp_rdata);
            chk({tag, ".hold_err"}, 32'(m_re), 32'(exp_err));
            chk({tag, ".hold_ready"}, 32'(m_rr), 32'd0);
        end
        set_valid(1'b0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".post_valid"}, 32'(m_rv), 32'd0);
        chk({tag, ".post_ready"}, 32'(m_rr), 32'd1);
        if (hold > 0) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                chk({tag, ".no_second_accept"}, 32'(m_rv), 32'd0);
            end
        end
    endtask

    initial begin
        sel        = 1'b0;
        rst        = 1'b1;
        va         = 1'b0;
        vb         = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = 4'hF;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", 32'(rr_a), 32'd0);
        chk("reset.resp_valid", 32'(rv_a), 32'd0);
        chk("reset.rdata", rd_a, 32'd0);
        chk("reset.err", 32'(re_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ready_after", 32'(rr_a), 32'd1);

        txn("st5",   1'b1, 32'd5,   32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0, 0);
        txn("ld5",   1'b0, 32'd5,   32'h0,        4'hF, 2, 32'hDEADBEEF, 1'b0, 0);
        txn("ld6",   1'b0, 32'd6,   32'h0,        4'hF, 2, 32'h0,        1'b0, 0);
        txn("ld255", 1'b0, 32'd255, 32'h0,        4'hF, 2, 32'h0,        1'b0, 0);
        txn("ld256", 1'b0, 32'd256, 32'h0,        4'hF, 2, 32'h0,        1'b1, 0);
        txn("st300", 1'b1, 32'd300, 32'hA5A5A5A5, 4'hF, 2, 32'h0,        1'b1, 0);
        txn("ld44",  1'b0, 32'd44,  32'h0,        4'hF, 2, 32'h0,        1'b0, 0);
        txn("ldhi",  1'b0, 32'h8000_0005, 32'h0,  4'hF, 2, 32'h0,        1'b1, 0);
        txn("bp5",   1'b0, 32'd5,   32'h0,        4'hF, 2, 32'hDEADBEEF, 1'b0, 10);

        // Reset lands while the store to 7 sits in WAIT; the write must be dropped.
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'd7;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        va        = 1'b1;
        @(posedge clk);
        #1;
        va  = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstwait.resp_valid", 32'(rv_a), 32'd0);
            chk("rstwait.req_ready", 32'(rr_a), 32'd0);
        end
        rst = 1'b0;
        txn("ld7",   1'b0, 32'd7,   32'h0,        4'hF, 2, 32'h0,        1'b0, 0);

        sel = 1'b1;
        txn("l1.st9", 1'b1, 32'd9,  32'hCAFEF00D, 4'hF, 1, 32'h0,        1'b0, 0);
        txn("l1.ld9", 1'b0, 32'd9,  32'h0,        4'hF, 1, 32'hCAFEF00D, 1'b0, 0);
        txn("l1.bad", 1'b1, 32'd256, 32'h1,       4'hF, 1, 32'h0,        1'b1, 0);
        txn("l1.bp",  1'b0, 32'd9,  32'h0,        4'hF, 1, 32'hCAFEF00D, 1'b0, 4);
        sel = 1'b0;

`ifdef DMEM_BYTE_WRITE_EN
        txn("be.full", 1'b1, 32'd3, 32'hFFFFFFFF, 4'b1111, 2, 32'h0,        1'b0, 0);
        txn("be.0101", 1'b1, 32'd3, 32'h00000000, 4'b0101, 2, 32'h0,        1'b0, 0);
        txn("be.ld1",  1'b0, 32'd3, 32'h0,        4'b0000, 2, 32'hFF00FF00, 1'b0, 0);
        txn("be.none", 1'b1, 32'd3, 32'h12345678, 4'b0000, 2, 32'h0,        1'b0, 0);
        txn("be.ld2",  1'b0, 32'd3, 32'h0,        4'b1010, 2, 32'hFF00FF00, 1'b0, 0);
`else
        txn("full.st3", 1'b1, 32'd3, 32'h0F0F0F0F, 4'b0000, 2, 32'h0,        1'b0, 0);
        txn("full.ld3", 1'b0, 32'd3, 32'h0,        4'b0000, 2, 32'h0F0F0F0F, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
